// File: rtl/lab2_proc_int_mul_iter.sv
// Iterative 32-bit shift-and-add multiplier for the TinyRV2 X stage.
// Fixed 32-iteration latency, val/rdy handshakes on request and response.
module lab2_proc_int_mul_iter #(
    parameter int nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic [2*nbits-1:0] req_msg,
    output logic               resp_val,
    input  logic               resp_rdy,
    output logic [nbits-1:0]   resp_msg
);

    localparam int CW = $clog2(nbits);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [nbits-1:0] r_a;
    logic [nbits-1:0] r_b;
    logic [nbits-1:0] r_result;
    logic [CW-1:0]    r_count;
    logic             r_idle;
    logic             r_resp_val;
    logic             w_req_go;

    // NOTE: req_rdy is the only output not purely registered; reset gates it
    // low so the X stage never sees a ready unit while reset is held.
    assign req_rdy  = r_idle & reset;
    assign resp_val = r_resp_val;
    assign resp_msg = r_result;
    assign w_req_go = req_val & req_rdy;

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours (a/b shift and the add in lockstep).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_result   <= '0;
            r_count    <= '0;
            r_idle     <= 1'b1;
            r_resp_val <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_go) begin
                        r_a      <= req_msg[2*nbits-1:nbits];
                        r_b      <= req_msg[nbits-1:0];
                        r_result <= '0;
                        r_count  <= '0;
                        r_state  <= S_CALC;
                        r_idle   <= 1'b0;
                    end
                end
                S_CALC: begin
                    if (r_b[0]) begin
                        r_result <= r_result + r_a;
                    end
                    r_a     <= r_a << 1;
                    r_b     <= r_b >> 1;
                    r_count <= r_count + CW'(1);
                    // No early exit on b==0: latency stays fixed for the stall logic.
                    if (r_count == CW'(nbits - 1)) begin
                        r_state    <= S_DONE;
                        r_resp_val <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (resp_rdy) begin
                        r_state    <= S_IDLE;
                        r_idle     <= 1'b1;
                        r_resp_val <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_idle     <= 1'b1;
                    r_resp_val <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lab2_proc_int_mul_iter.sv
// Directed and random self-checking bench for lab2_proc_int_mul_iter.
module tb_lab2_proc_int_mul_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_val;
    logic        req_rdy;
    logic [63:0] req_msg;
    logic        resp_val;
    logic        resp_rdy;
    logic [31:0] resp_msg;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int prev_accept = 0;
    int hsk_cyc = 0;

    lab2_proc_int_mul_iter #(.nbits(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_msg  (req_msg),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_msg (resp_msg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait (bounded) for ready, and take the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input string tag);
        int w;
        w = 0;
        req_msg = {a, b};
        req_val = 1'b1;
        while (!req_rdy && w < 200) begin
            tick();
            w++;
        end
        check({tag, "_rdy_wait"}, {31'd0, req_rdy}, 32'd1);
        tick();
        accept_cyc = cyc;
        req_val = 1'b0;
        check({tag, "_busy"}, {31'd0, req_rdy}, 32'd0);
    endtask

    task automatic wait_resp(input string tag);
        int w;
        w = 0;
        while (!resp_val && w < 200) begin
            tick();
            w++;
        end
        check({tag, "_lat"}, cyc - accept_cyc, 32'd32);
    endtask

    // Check the product, optionally stall with resp_rdy low, then handshake.
    task automatic finish_resp(input string tag, input logic [31:0] exp, input int stall);
        check({tag, "_val"}, {31'd0, resp_val}, 32'd1);
        check({tag, "_msg"}, resp_msg, exp);
        resp_rdy = 1'b0;
        for (int i = 0; i < stall; i++) begin
            tick();
            check({tag, "_hold_val"}, {31'd0, resp_val}, 32'd1);
            check({tag, "_hold_msg"}, resp_msg, exp);
        end
        resp_rdy = 1'b1;
        tick();
        hsk_cyc = cyc;
        check({tag, "_post_val"}, {31'd0, resp_val}, 32'd0);
        check({tag, "_post_rdy"}, {31'd0, req_rdy}, 32'd1);
    endtask

    initial begin
        logic [31:0] ra, rb, rexp;
        bit          seen;

        reset    = 1'b0;
        req_val  = 1'b0;
        req_msg  = '0;
        resp_rdy = 1'b1;
        #1;
        tick();
        tick();
        check("rst_rdy", {31'd0, req_rdy}, 32'd0);
        check("rst_val", {31'd0, resp_val}, 32'd0);
        check("rst_msg", resp_msg, 32'd0);
        reset = 1'b1;
        #1;
        check("rel_rdy", {31'd0, req_rdy}, 32'd1);

        // Basic product
        send(32'd3, 32'd4, "basic");
        wait_resp("basic");
        finish_resp("basic", 32'h0000000C, 0);

        // Signed / overflow, back-to-back
        send(32'hFFFFFFFE, 32'd3, "neg2x3");
        prev_accept = accept_cyc;
        wait_resp("neg2x3");
        finish_resp("neg2x3", 32'hFFFFFFFA, 0);
        send(32'h80000000, 32'd2, "ovf");
        check("ovf_spacing", accept_cyc - prev_accept, 32'd34);
        prev_accept = accept_cyc;
        wait_resp("ovf");
        finish_resp("ovf", 32'h00000000, 0);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, "m1xm1");
        check("m1xm1_spacing", accept_cyc - prev_accept, 32'd34);
        wait_resp("m1xm1");
        finish_resp("m1xm1", 32'h00000001, 0);

        // Backpressure
        send(32'd7, 32'd6, "bp");
        resp_rdy = 1'b0;
        wait_resp("bp");
        finish_resp("bp", 32'h0000002A, 5);

        // Busy-ignore: second request held during CALC
        send(32'd5, 32'd5, "busy1");
        tick();
        tick();
        req_msg = {32'd9, 32'd9};
        req_val = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("busy_rdy_low", {31'd0, req_rdy}, 32'd0);
        end
        wait_resp("busy1");
        finish_resp("busy1", 32'h00000019, 0);
        tick();
        accept_cyc = cyc;
        req_val = 1'b0;
        check("busy2_accept_gap", accept_cyc - hsk_cyc, 32'd1);
        check("busy2_taken", {31'd0, req_rdy}, 32'd0);
        wait_resp("busy2");
        finish_resp("busy2", 32'h00000051, 0);

        // Reset mid-operation
        send(32'd100, 32'd100, "rstmid");
        repeat (10) tick();
        #2;
        reset = 1'b0;
        #1;
        check("rstmid_val", {31'd0, resp_val}, 32'd0);
        check("rstmid_rdy", {31'd0, req_rdy}, 32'd0);
        check("rstmid_msg", resp_msg, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("rstmid_rel_rdy", {31'd0, req_rdy}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (resp_val) seen = 1'b1;
        end
        check("rstmid_no_resp", {31'd0, seen}, 32'd0);
        send(32'd7, 32'd6, "after_rst");
        wait_resp("after_rst");
        finish_resp("after_rst", 32'h0000002A, 0);

        // Random vectors against a truncated reference product
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom();
            rb = $urandom();
            if (n == 0) begin ra = 32'h0; rb = 32'hFFFFFFFF; end
            if (n == 1) begin ra = 32'hFFFFFFFF; rb = 32'h1; end
            rexp = ra * rb;
            send(ra, rb, "rand");
            resp_rdy = 1'($urandom_range(0, 1));
            wait_resp("rand");
            finish_resp("rand", rexp, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
